// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin conditioning, frame check, prefix folding
// and a show-ahead FIFO of {ext, brk, code} entries with sticky errors.
module ps2_rx_fifo #(
  parameter int FIFO_AW        = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int RAW_MODE       = 0
) (
  input  logic               Bus2IP_Clk,
  input  logic               Bus2IP_Reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rd_en,
  output logic [9:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  input  logic               err_clr,
  output logic               overflow,
  output logic               parity_err,
  output logic               frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [FIFO_AW:0] C_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] C_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] P_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_EXT, S_BRK, S_EXT_BRK
  } state_t;

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic [3:0] clk_cnt;
  logic [3:0] dat_cnt;
  logic       clk_f;
  logic       dat_f;
  logic       clk_prev;
  logic       fall;

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_f;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      clk_f   <= 1'b1;
      clk_cnt <= '0;
    end else if (clk_sync[1] == clk_f) begin
      clk_cnt <= '0;
    end else if (clk_cnt == FL_LAST) begin
      clk_f   <= clk_sync[1];
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 4'd1;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      dat_f   <= 1'b1;
      dat_cnt <= '0;
    end else if (dat_sync[1] == dat_f) begin
      dat_cnt <= '0;
    end else if (dat_cnt == FL_LAST) begin
      dat_f   <= dat_sync[1];
      dat_cnt <= '0;
    end else begin
      dat_cnt <= dat_cnt + 4'd1;
    end
  end

  assign fall = clk_prev & ~clk_f;

  logic [3:0]    bitcnt;
  logic [7:0]    sr;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          byte_valid;
  logic [7:0]    byte_q;
  logic          ferr_p;
  logic          perr_p;

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      bitcnt     <= '0;
      sr         <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      byte_q     <= '0;
      ferr_p     <= 1'b0;
      perr_p     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      ferr_p     <= 1'b0;
      perr_p     <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        unique case (1'b1)
          (bitcnt == 4'd0): begin
            // a high start bit is line noise, not a frame
            if (dat_f) ferr_p <= 1'b1;
            else       bitcnt <= 4'd1;
          end
          (bitcnt == 4'd9): begin
            par    <= dat_f;
            bitcnt <= 4'd10;
          end
          (bitcnt == 4'd10): begin
            bitcnt <= '0;
            if (!dat_f) begin
              ferr_p <= 1'b1;
            end else if (^{sr, par}) begin
              byte_valid <= 1'b1;
              byte_q     <= sr;
            end else begin
              perr_p <= 1'b1;
            end
          end
          default: begin
            sr     <= {dat_f, sr[7:1]};
            bitcnt <= bitcnt + 4'd1;
          end
        endcase
      end else if (bitcnt != 4'd0) begin
        if (tcnt == TO_LAST) begin
          tcnt   <= '0;
          bitcnt <= '0;
          ferr_p <= 1'b1;
        end else begin
          tcnt <= tcnt + T_ONE;
        end
      end
    end
  end

  state_t     state;
  state_t     state_nxt;
  logic       push;
  logic [9:0] push_data;
  logic       is_e0;
  logic       is_f0;

  assign is_e0 = (byte_q == 8'hE0);
  assign is_f0 = (byte_q == 8'hF0);

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    if (ferr_p || perr_p) begin
      state_nxt = S_IDLE;
    end else if (byte_valid) begin
      if (RAW_MODE != 0) begin
        push      = 1'b1;
        push_data = {2'b00, byte_q};
      end else begin
        unique case (state)
          S_IDLE: begin
            if (is_e0)      state_nxt = S_EXT;
            else if (is_f0) state_nxt = S_BRK;
            else begin
              push      = 1'b1;
              push_data = {2'b00, byte_q};
            end
          end
          S_EXT: begin
            if (is_f0)      state_nxt = S_EXT_BRK;
            else if (!is_e0) begin
              push      = 1'b1;
              push_data = {2'b10, byte_q};
              state_nxt = S_IDLE;
            end
          end
          S_BRK: begin
            if (is_e0)      state_nxt = S_EXT_BRK;
            else if (!is_f0) begin
              push      = 1'b1;
              push_data = {2'b01, byte_q};
              state_nxt = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            if (!is_e0 && !is_f0) begin
              push      = 1'b1;
              push_data = {2'b11, byte_q};
              state_nxt = S_IDLE;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   cnt;
  logic               do_pop;
  logic               do_push;
  logic               ovf_ev;

  assign empty   = (cnt == '0);
  assign full    = (cnt == C_FULL);
  assign count   = cnt;
  assign rd_data = empty ? 10'd0 : mem[rptr];
  assign do_pop  = rd_en & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push & (~full | do_pop);
  assign ovf_ev  = push & full & ~do_pop;

  always_ff @(posedge Bus2IP_Clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + P_ONE;
      if (do_pop)  rptr <= rptr + P_ONE;
      if (do_push && !do_pop)      cnt <= cnt + C_ONE;
      else if (do_pop && !do_push) cnt <= cnt - C_ONE;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ovf_ev)       overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (perr_p)       parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (ferr_p)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: three instances (default, 4-deep, raw mode)
// driven with PS/2 frames and checked against per-instance queues.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pclk [3];
  logic       pdat [3];
  logic       rd   [3];
  logic       eclr [3];
  logic [9:0] rdd  [3];
  logic       emp  [3];
  logic       ful  [3];
  logic       ovf  [3];
  logic       perr [3];
  logic       ferr [3];
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  logic [4:0] cnt2;

  int n_chk = 0;
  int n_err = 0;

  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [9:0] q2 [$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FIFO_AW(4), .RAW_MODE(0)) dut0 (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst),
    .ps2_clk(pclk[0]), .ps2_data(pdat[0]), .rd_en(rd[0]),
    .rd_data(rdd[0]), .empty(emp[0]), .full(ful[0]), .count(cnt0),
    .err_clr(eclr[0]), .overflow(ovf[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]));

  ps2_rx_fifo #(.FIFO_AW(2), .RAW_MODE(0)) dut1 (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst),
    .ps2_clk(pclk[1]), .ps2_data(pdat[1]), .rd_en(rd[1]),
    .rd_data(rdd[1]), .empty(emp[1]), .full(ful[1]), .count(cnt1),
    .err_clr(eclr[1]), .overflow(ovf[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]));

  ps2_rx_fifo #(.FIFO_AW(4), .RAW_MODE(1)) dut2 (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst),
    .ps2_clk(pclk[2]), .ps2_data(pdat[2]), .rd_en(rd[2]),
    .rd_data(rdd[2]), .empty(emp[2]), .full(ful[2]), .count(cnt2),
    .err_clr(eclr[2]), .overflow(ovf[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [9:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int k, output logic [9:0] v);
    v = 10'h3FF;
    case (k)
      0: if (q0.size() > 0) v = q0.pop_front();
      1: if (q1.size() > 0) v = q1.pop_front();
      default: if (q2.size() > 0) v = q2.pop_front();
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // act: 0 none, 1 check push latency, 2 pop in the push cycle
  task automatic ps2_send(input int k, input logic [7:0] b,
                          input bit bad_par, input int nbits,
                          input int act);
    logic [10:0] fr;
    logic [9:0]  e;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      pdat[k] = fr[i];
      idle(4);
      pclk[k] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (i == 10 && j == 6 && act == 1)
          chk("lat_empty_hi", 32'(emp[k]), 32'd1);
        if (i == 10 && j == 7 && act == 1)
          chk("lat_empty_lo", 32'(emp[k]), 32'd0);
        if (i == 10 && j == 6 && act == 2) begin
          sb_pop(k, e);
          chk("simul_head", 32'(rdd[k]), 32'(e));
          rd[k] = 1'b1;
        end
        if (i == 10 && j == 7 && act == 2) rd[k] = 1'b0;
      end
      pclk[k] = 1'b1;
      idle(4);
    end
    pdat[k] = 1'b1;
  endtask

  task automatic send(input int k, input logic [7:0] b);
    ps2_send(k, b, 1'b0, 11, 0);
    idle(20);
  endtask

  task automatic pop(input int k, input string tag);
    logic [9:0] e;
    @(negedge clk);
    sb_pop(k, e);
    chk({tag, "_nonempty"}, 32'(emp[k]), 32'd0);
    chk(tag, 32'(rdd[k]), 32'(e));
    rd[k] = 1'b1;
    @(negedge clk);
    rd[k] = 1'b0;
  endtask

  task automatic clr(input int k);
    @(negedge clk);
    eclr[k] = 1'b1;
    @(negedge clk);
    eclr[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      pclk[k] = 1'b1;
      pdat[k] = 1'b1;
      rd[k]   = 1'b0;
      eclr[k] = 1'b0;
    end
    rst = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(2);

    chk("rst_rd_data", 32'(rdd[0]), 32'd0);
    chk("rst_empty", 32'(emp[0]), 32'd1);
    chk("rst_full", 32'(ful[0]), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_ovf", 32'(ovf[0]), 32'd0);
    chk("rst_perr", 32'(perr[0]), 32'd0);
    chk("rst_ferr", 32'(ferr[0]), 32'd0);

    sb_push(0, 10'h01C);
    ps2_send(0, 8'h1C, 1'b0, 11, 1);
    idle(20);
    chk("one_count", 32'(cnt0), 32'd1);
    pop(0, "pop_1c");
    @(negedge clk);
    chk("after_pop_empty", 32'(emp[0]), 32'd1);
    chk("after_pop_count", 32'(cnt0), 32'd0);

    sb_push(0, 10'h375);
    send(0, 8'hE0);
    send(0, 8'hF0);
    send(0, 8'h75);
    chk("extbrk_count", 32'(cnt0), 32'd1);
    pop(0, "pop_375");
    sb_push(0, 10'h11C);
    send(0, 8'hF0);
    send(0, 8'h1C);
    pop(0, "pop_11c");

    ps2_send(0, 8'h1C, 1'b1, 11, 0);
    idle(20);
    chk("par_err_set", 32'(perr[0]), 32'd1);
    chk("par_no_push", 32'(emp[0]), 32'd1);
    clr(0);
    chk("par_err_clr", 32'(perr[0]), 32'd0);
    sb_push(0, 10'h032);
    send(0, 8'h32);
    pop(0, "pop_032");

    ps2_send(0, 8'h1C, 1'b0, 5, 0);
    idle(1900);
    chk("to_not_yet", 32'(ferr[0]), 32'd0);
    idle(150);
    chk("to_ferr", 32'(ferr[0]), 32'd1);
    chk("to_no_push", 32'(emp[0]), 32'd1);
    clr(0);
    sb_push(0, 10'h01C);
    send(0, 8'h1C);
    pop(0, "pop_after_to");
    chk("to_ferr_clean", 32'(ferr[0]), 32'd0);

    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb_push(1, 10'(8'h11 + i));
      send(1, 8'(8'h11 + i));
    end
    chk("ovf_full", 32'(ful[1]), 32'd1);
    chk("ovf_count", 32'(cnt1), 32'd4);
    chk("ovf_flag", 32'(ovf[1]), 32'd1);
    clr(1);
    chk("ovf_clr", 32'(ovf[1]), 32'd0);
    sb_push(1, 10'h016);
    ps2_send(1, 8'h16, 1'b0, 11, 2);
    idle(20);
    chk("simul_count", 32'(cnt1), 32'd4);
    chk("simul_ovf", 32'(ovf[1]), 32'd0);
    chk("simul_full", 32'(ful[1]), 32'd1);
    for (int i = 0; i < 4; i++) pop(1, "drain");
    @(negedge clk);
    chk("drain_empty", 32'(emp[1]), 32'd1);

    sb_push(2, 10'h0F0);
    sb_push(2, 10'h01C);
    send(2, 8'hF0);
    send(2, 8'h1C);
    chk("raw_count", 32'(cnt2), 32'd2);
    pop(2, "raw_f0");
    pop(2, "raw_1c");

    @(negedge clk);
    pclk[2] = 1'b0;
    @(negedge clk);
    pclk[2] = 1'b1;
    idle(30);
    chk("glitch_ferr", 32'(ferr[2]), 32'd0);
    chk("glitch_empty", 32'(emp[2]), 32'd1);
    sb_push(2, 10'h05A);
    send(2, 8'h5A);
    pop(2, "glitch_next");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 keyboard receiver: synchroniser, glitch filter, 11-bit frame checker, make/break/extended prefix decoder and show-ahead FIFO.
- Successor to the fixed single-byte keyboard front end.
- Adds configurable FIFO depth, E0/F0 prefix folding, raw mode, frame timeout, and sticky error flags.
- Sits between the PS/2 pins and the bus-register logic, which pops entries via rd_en.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.
- FILTER_LEN, 4, consecutive equal samples (2..15) required before filtered ps2_clk/ps2_data change.
- TIMEOUT_CYCLES, 2000, idle cycles mid-frame before the partial frame is discarded.
- RAW_MODE, 0, 1 = push every received byte unmodified (ext=brk=0, prefixes pushed too).

Ports:
- Bus2IP_Clk  in  1  system clock; all logic on rising edge.
- Bus2IP_Reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- rd_en  in  1  pop head entry.
- rd_data  out  10  head entry {ext, brk, code[7:0]}; valid while empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  FIFO_AW+1  occupancy.
- err_clr  in  1  clears all sticky error flags.
- overflow  out  1  sticky: entry dropped because FIFO was full.
- parity_err  out  1  sticky: frame failed odd parity.
- frame_err  out  1  sticky: bad start bit, bad stop bit, or timeout.

Behaviour:
- Reset: rd_data=0, empty=1, full=0, count=0, overflow=0, parity_err=0, frame_err=0.
  - Reset also clears the bit counter and decoder state, and sets the filtered clk/data outputs to 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - Two-flop synchroniser on each pin.
  - Per-line filter counter: the filtered output takes the new level only after FILTER_LEN consecutive cycles at that level.
  - Falling edge = filtered ps2_clk 1->0, detected as a single-cycle pulse.
- Frame receiver (bit counter 0..10, shift register):
  - Each falling edge samples filtered data. Bit 0 start, bits 1-8 data LSB first, bit 9 parity, bit 10 stop.
  - Start bit = 1: frame_err set, counter returns to 0 (the bit is treated as noise).
  - At bit 10, a frame is valid when stop=1 and XOR(data, parity)=1. A valid frame raises byte_valid the next cycle.
  - Stop=0 sets frame_err; parity mismatch sets parity_err. Neither produces a byte.
  - Timeout counter clears on every falling edge and counts while the bit counter is nonzero. On reaching TIMEOUT_CYCLES: counter returns to 0, frame_err set.
- Decoder FSM (RAW_MODE=0), states IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> push {0,0,b}.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; other -> push {1,0,b}, IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> BRK; other -> push {0,1,b}, IDLE.
  - EXT_BRK: E0/F0 -> stay; other -> push {1,1,b}, IDLE.
  - frame_err or parity_err event returns the FSM to IDLE.
- RAW_MODE=1: every valid byte is pushed as {0,0,b}; the FSM is unused.
- Push latency: push occurs the cycle byte_valid is high. empty falls, and rd_data shows the entry, on the following cycle.
- FIFO, show-ahead:
  - rd_en with empty=0 pops; the next entry appears the next cycle. rd_en with empty=1 is ignored.
  - Push with full=1 and no pop: entry dropped, overflow set, count unchanged.
  - Push and pop in the same cycle: both occur (full or not), count unchanged, no overflow.
  - Pointers wrap modulo 2**FIFO_AW.
- Sticky flags hold until err_clr or reset. If err_clr and a new error occur in the same cycle, the flag stays set.

Test Plan:
- FILTER_LEN=4, RAW_MODE=0, PS/2 half-period 8 cycles, frame 1C with correct parity -> empty=0 two cycles after the stop-bit edge, rd_data=0x01C; rd_en pops -> empty=1, count=0.
- Sequence E0 F0 75 -> exactly one entry, rd_data=0x375; sequence F0 1C -> rd_data=0x11C.
- Frame 1C with parity bit inverted -> parity_err=1, no push; err_clr pulse -> parity_err=0; next valid 32 -> rd_data=0x032.
- Send 5 clock edges, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err=1, bit counter 0; next full frame 1C -> rd_data=0x01C.
- FIFO_AW=2: push 5 bytes 11..15 without reads -> full=1, count=4, overflow=1; reads return 0x011..0x014.
  - With full=1, push and rd_en in the same cycle -> overflow unchanged, count stays 4.
- RAW_MODE=1, bytes F0 1C -> two entries 0x0F0, 0x01C.
  - 1-cycle glitch low on ps2_clk -> ignored, no bit sampled.
